execute_muldiv: RTL

Parametrised successor to the execute stage: a registered execute unit with a valid/ready handshake on both sides. It performs single-cycle ALU, LUI, AUIPC, JAL/JALR link, and store-data/address operations. It adds an iterative RV-M multiply/divide path that takes XLEN cycles. It sits between fetch/decode and writeback in the three-stage pipeline and provides back-pressure while a multiply or divide is in flight.

---
 rtl/exec_pkg.sv | 9 +
 rtl/muldiv_iter.sv | 97 +++++++++
 rtl/execute_muldiv.sv | 103 ++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: kind/funct3 encodings and state enum shared by the execute stage
package exec_pkg;
  typedef enum logic [2:0] {K_ALU, K_MEMWR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_MULDIV, K_RSVD} kind_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_e;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SLL = 3'd1, OP_SLT = 3'd2, OP_SLTU = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SRL = 3'd5, OP_OR = 3'd6, OP_AND = 3'd7;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: XLEN-cycle shift-add multiplier / restoring divider on operand magnitudes
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  logic busy_q, busy_d, neg_q, neg_d, negr_q, negr_d, div0_q, div0_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic sa, sb, an, bn, ge;
  logic [XLEN-1:0] ma, mb, nhi, nlo;
  logic [XLEN:0] sum, sh;
  logic [2*XLEN-1:0] prod;
  always_comb begin
    sa = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    sb = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    an = sa & a[XLEN-1];
    bn = sb & b[XLEN-1];
    ma = an ? -a : a;
    mb = bn ? -b : b;
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    sh = {hi_q, lo_q[XLEN-1]};
    ge = sh >= {1'b0, m_q};
    nhi = op_q[2] ? (ge ? XLEN'(sh - {1'b0, m_q}) : sh[XLEN-1:0]) : sum[XLEN:1];
    nlo = op_q[2] ? {lo_q[XLEN-2:0], ge} : {sum[0], lo_q[XLEN-1:1]};
    prod = neg_q ? -{nhi, nlo} : {nhi, nlo};
    busy = busy_q;
    done = busy_q && cnt_q == '0;
    // signed MIN/-1 falls out of the magnitude path; only divide-by-zero quotient needs forcing
    result = op_q == OP_MUL ? prod[XLEN-1:0] : !op_q[2] ? prod[2*XLEN-1:XLEN] :
             !op_q[1] ? (div0_q ? '1 : (neg_q ? -nlo : nlo)) : (negr_q ? -nhi : nhi);
    busy_d = busy_q;
    cnt_d = cnt_q;
    op_d = op_q;
    hi_d = hi_q;
    lo_d = lo_q;
    m_d = m_q;
    neg_d = neg_q;
    negr_d = negr_q;
    div0_d = div0_q;
    if (flush) begin
      busy_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d = CW'(XLEN - 1);
      op_d = op;
      hi_d = '0;
      lo_d = op[2] ? ma : mb;
      m_d = op[2] ? mb : ma;
      neg_d = an ^ bn;
      negr_d = an;
      div0_d = b == '0;
    end else if (busy_q) begin
      busy_d = cnt_q != '0;
      cnt_d = cnt_q - 1'b1;
      hi_d = nhi;
      lo_d = nlo;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetb) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
      op_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      neg_q <= 1'b0;
      negr_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
      neg_q <= neg_d;
      negr_q <= negr_d;
      div0_q <= div0_d;
    end
  end
endmodule

// File: rtl/execute_muldiv.sv
// execute_muldiv: registered execute stage with valid/ready handshake and iterative RV-M path
module execute_muldiv
  import exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_kind,
  input  logic [2:0]      in_op,
  input  logic            in_subtype,
  input  logic            in_imm_sel,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_dst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_addr,
  output logic [4:0]      out_dst,
  output logic            out_err
);
  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  state_e state_q, state_d;
  logic [XLEN-1:0] out_result_q, out_result_d, out_addr_q, out_addr_d;
  logic [4:0] out_dst_q, out_dst_d;
  logic out_err_q, out_err_d;
  logic accept, is_md, lt_s, md_busy, md_done;
  logic [XLEN:0] sub;
  logic [XLEN-1:0] op2, sra, alu, res, md_result;
  logic [SW-1:0] shamt;
  assign in_ready = state_q == S_IDLE || (state_q == S_HOLD && out_ready);
  assign out_valid = state_q == S_HOLD;
  assign out_result = out_result_q;
  assign out_addr = out_addr_q;
  assign out_dst = out_dst_q;
  assign out_err = out_err_q;
  muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk(clk), .resetb(resetb), .flush(flush), .start(accept && is_md), .op(in_op),
    .a(in_rs1), .b(op2), .busy(md_busy), .done(md_done), .result(md_result)
  );
  always_comb begin
    accept = in_valid && in_ready && !flush;
    is_md = EN_M && in_kind == K_MULDIV;
    op2 = in_imm_sel ? in_imm : in_rs2;
    shamt = op2[SW-1:0];
    sub = {1'b0, in_rs1} - {1'b0, op2};
    // signed borrow of the sign-extended subtraction equals the unsigned borrow xor both signs
    lt_s = in_rs1[XLEN-1] ^ op2[XLEN-1] ^ sub[XLEN];
    sra = $unsigned($signed(in_rs1) >>> shamt);
    alu = in_op == OP_ADD ? (in_subtype ? sub[XLEN-1:0] : in_rs1 + op2) :
          in_op == OP_SLL ? in_rs1 << shamt :
          in_op == OP_SLT ? {{(XLEN-1){1'b0}}, lt_s} :
          in_op == OP_SLTU ? {{(XLEN-1){1'b0}}, sub[XLEN]} :
          in_op == OP_XOR ? in_rs1 ^ op2 :
          in_op == OP_SRL ? (in_subtype ? sra : in_rs1 >> shamt) :
          in_op == OP_OR ? in_rs1 | op2 : in_rs1 & op2;
    res = in_kind == K_ALU ? alu : in_kind == K_MEMWR ? op2 :
          (in_kind == K_JAL || in_kind == K_JALR) ? in_pc + FOUR :
          in_kind == K_LUI ? in_imm : in_kind == K_AUIPC ? in_pc + in_imm : '0;
    state_d = state_q;
    out_result_d = out_result_q;
    out_addr_d = out_addr_q;
    out_dst_d = out_dst_q;
    out_err_d = out_err_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (accept) begin
      state_d = is_md ? S_BUSY : S_HOLD;
      out_result_d = res;
      out_addr_d = in_rs1 + in_imm;
      out_dst_d = in_dst;
      out_err_d = in_kind == K_RSVD;
    end else if (state_q == S_HOLD && out_ready) begin
      state_d = S_IDLE;
    end else if (md_busy && md_done) begin
      state_d = S_HOLD;
      out_result_d = md_result;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      out_result_q <= '0;
      out_addr_q <= '0;
      out_dst_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_result_q <= out_result_d;
      out_addr_q <= out_addr_d;
      out_dst_q <= out_dst_d;
      out_err_q <= out_err_d;
    end
  end
endmodule
